// File: rtl/mem_bus_arbiter.sv
// N-master arbiter onto one shared two-phase SRAM-like bus, single outstanding transaction, fixed-priority or round-robin.
// Request-to-bus_req 1 cycle, request-to-done >= 2 cycles; ARB_PERF_CNT_EN adds per-master grant/wait counters.
module mem_bus_arbiter #(
   parameter int NUM_M    = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_M-1:0]          m_req,
   input  logic [NUM_M-1:0]          m_wr,
   input  logic [NUM_M*DATA_W/8-1:0] m_wstrb,
   input  logic [NUM_M*ADDR_W-1:0]   m_addr,
   input  logic [NUM_M*DATA_W-1:0]   m_wdata,
   output logic [DATA_W-1:0]         m_rdata,
   output logic [NUM_M-1:0]          m_done,
   output logic [NUM_M-1:0]          m_stall,
   output logic                      bus_req,
   output logic                      bus_wr,
   output logic [DATA_W/8-1:0]       bus_wstrb,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [DATA_W-1:0]         bus_wdata,
   input  logic                      bus_addr_ok,
   input  logic                      bus_data_ok,
   input  logic [DATA_W-1:0]         bus_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   input  logic                      perf_clr,
   output logic [NUM_M*32-1:0]       perf_grant_cnt,
   output logic [NUM_M*32-1:0]       perf_wait_cnt
`endif
);
   localparam int SW = DATA_W / 8;
   localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nxt;

   logic [IW-1:0]    grant;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    win_idx;
   logic             win_vld;
   logic [NUM_M-1:0] eligible;
   logic             take;
   logic             complete;

   function automatic logic [IW-1:0] wrap_idx(input int v);
      return IW'(v % NUM_M);
   endfunction

   // A master in its done cycle is masked so it cannot be re-granted back to back.
   assign eligible = m_req & ~m_done;
   assign m_stall  = m_req & ~m_done;
   assign bus_req  = (state == ADDR);

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      if (ARB_MODE == 0) begin
         for (int i = NUM_M - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               win_vld = 1'b1;
               win_idx = IW'(i);
            end
         end
      end else begin
         // Walk backwards so the candidate closest after rr_ptr is written last.
         for (int s = NUM_M; s >= 1; s--) begin
            if (eligible[wrap_idx(int'(rr_ptr) + s)]) begin
               win_vld = 1'b1;
               win_idx = wrap_idx(int'(rr_ptr) + s);
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               take      = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  complete  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (bus_data_ok) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= IW'(NUM_M - 1);
         bus_wr    <= 1'b0;
         bus_wstrb <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         m_done    <= '0;
         m_rdata   <= '0;
      end else begin
         state  <= state_nxt;
         m_done <= '0;
         if (take) begin
            grant     <= win_idx;
            rr_ptr    <= win_idx;
            bus_wr    <= m_wr[win_idx];
            bus_wstrb <= m_wstrb[win_idx*SW +: SW];
            bus_addr  <= m_addr[win_idx*ADDR_W +: ADDR_W];
            bus_wdata <= m_wdata[win_idx*DATA_W +: DATA_W];
         end
         if (complete) begin
            m_done[grant] <= 1'b1;
            if (!bus_wr) begin
               m_rdata <= bus_rdata;
            end
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] grant_cnt [NUM_M];
   logic [31:0] wait_cnt  [NUM_M];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_M; i++) begin
         if (rst || perf_clr) begin
            grant_cnt[i] <= '0;
            wait_cnt[i]  <= '0;
         end else begin
            if (take && (win_idx == IW'(i))) begin
               grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
            if (m_stall[i]) begin
               wait_cnt[i] <= wait_cnt[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_M; g++) begin : g_perf
      assign perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
      assign perf_wait_cnt[g*32 +: 32]  = wait_cnt[g];
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 2-master fixed-priority and a 4-master round-robin instance share one stimulus;
// a transaction-level reference model checks both every cycle, plus a hand-derived vector table and directed sequences.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         addr_ok = 1'b0;
   logic         data_ok = 1'b0;
   logic         perf_clr = 1'b0;
   logic [3:0]   req = '0;
   logic [3:0]   wr = '0;
   logic [15:0]  wstrb = '0;
   logic [127:0] addr = '0;
   logic [127:0] wdata = '0;
   logic [31:0]  rdata_in = '0;

   logic [31:0] fp_rdata, fp_bus_addr, fp_bus_wdata;
   logic [1:0]  fp_done, fp_stall;
   logic        fp_bus_req, fp_bus_wr;
   logic [3:0]  fp_bus_wstrb;
   logic [31:0] rr_rdata, rr_bus_addr, rr_bus_wdata;
   logic [3:0]  rr_done, rr_stall;
   logic        rr_bus_req, rr_bus_wr;
   logic [3:0]  rr_bus_wstrb;
`ifdef ARB_PERF_CNT_EN
   logic [63:0]  fp_pg, fp_pw;
   logic [127:0] rr_pg, rr_pw;
`endif

   mem_bus_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst(rst), .m_req(req[1:0]), .m_wr(wr[1:0]), .m_wstrb(wstrb[7:0]),
      .m_addr(addr[63:0]), .m_wdata(wdata[63:0]), .m_rdata(fp_rdata), .m_done(fp_done),
      .m_stall(fp_stall), .bus_req(fp_bus_req), .bus_wr(fp_bus_wr), .bus_wstrb(fp_bus_wstrb),
      .bus_addr(fp_bus_addr), .bus_wdata(fp_bus_wdata), .bus_addr_ok(addr_ok),
      .bus_data_ok(data_ok), .bus_rdata(rdata_in)
`ifdef ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_grant_cnt(fp_pg), .perf_wait_cnt(fp_pw)
`endif
   );

   mem_bus_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .m_req(req), .m_wr(wr), .m_wstrb(wstrb),
      .m_addr(addr), .m_wdata(wdata), .m_rdata(rr_rdata), .m_done(rr_done),
      .m_stall(rr_stall), .bus_req(rr_bus_req), .bus_wr(rr_bus_wr), .bus_wstrb(rr_bus_wstrb),
      .bus_addr(rr_bus_addr), .bus_wdata(rr_bus_wdata), .bus_addr_ok(addr_ok),
      .bus_data_ok(data_ok), .bus_rdata(rdata_in)
`ifdef ARB_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_grant_cnt(rr_pg), .perf_wait_cnt(rr_pw)
`endif
   );

   // Observed outputs normalised to 4 masters; index 0 = fixed-priority DUT, 1 = round-robin DUT.
   logic [3:0]  o_done  [2];
   logic [3:0]  o_stall [2];
   logic        o_breq  [2];
   logic [31:0] o_rdata [2];
   logic [68:0] o_fields[2];
   assign o_done[0]   = {2'b00, fp_done};
   assign o_done[1]   = rr_done;
   assign o_stall[0]  = {2'b00, fp_stall};
   assign o_stall[1]  = rr_stall;
   assign o_breq[0]   = fp_bus_req;
   assign o_breq[1]   = rr_bus_req;
   assign o_rdata[0]  = fp_rdata;
   assign o_rdata[1]  = rr_rdata;
   assign o_fields[0] = {fp_bus_wr, fp_bus_wstrb, fp_bus_addr, fp_bus_wdata};
   assign o_fields[1] = {rr_bus_wr, rr_bus_wstrb, rr_bus_addr, rr_bus_wdata};

   int n_chk = 0;
   int n_fail = 0;

   task automatic cmp(input string name, input int idx, input logic [68:0] act, input logic [68:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d] t=%0t actual=%h expected=%h", name, idx, $time, act, exp);
      end
   endtask

   // Transaction-level reference model: one in-flight transaction per arbiter.
   bit          md_busy [2];
   bit          md_acc  [2];
   int          md_g    [2];
   int          md_ptr  [2];
   logic [3:0]  md_done [2];
   logic [31:0] md_rdata[2];
   logic [68:0] md_fields[2];
   int unsigned md_pg [2][4];
   int unsigned md_pw [2][4];

   function automatic logic [3:0] msk(input int k);
      return (k == 0) ? 4'b0011 : 4'b1111;
   endfunction

   task automatic model_step(input int k);
      int n, w;
      bit fin;
      logic [3:0] elig, stall, nd;
      n = (k == 0) ? 2 : 4;
      if (rst) begin
         md_busy[k] = 0; md_acc[k] = 0; md_g[k] = 0; md_ptr[k] = n - 1;
         md_done[k] = '0; md_rdata[k] = '0; md_fields[k] = '0;
         for (int i = 0; i < 4; i++) begin
            md_pg[k][i] = 0;
            md_pw[k][i] = 0;
         end
         return;
      end
      stall = req & ~md_done[k] & msk(k);
      nd = '0;
      fin = 0;
      w = -1;
      if (!md_busy[k]) begin
         elig = stall;
         if (k == 0) begin
            for (int i = 0; i < n; i++) if (w < 0 && elig[i]) w = i;
         end else begin
            for (int s = 1; s <= n; s++) begin
               int j;
               j = (md_ptr[k] + s) % n;
               if (w < 0 && elig[j]) w = j;
            end
         end
         if (w >= 0) begin
            md_busy[k] = 1; md_acc[k] = 0; md_g[k] = w; md_ptr[k] = w;
            md_fields[k] = {wr[w], wstrb[w*4 +: 4], addr[w*32 +: 32], wdata[w*32 +: 32]};
         end
      end else if (!md_acc[k]) begin
         if (addr_ok && data_ok) fin = 1;
         else if (addr_ok) md_acc[k] = 1;
      end else if (data_ok) begin
         fin = 1;
      end
      if (fin) begin
         md_busy[k] = 0;
         md_acc[k] = 0;
         nd[md_g[k]] = 1'b1;
         if (!md_fields[k][68]) md_rdata[k] = rdata_in;
      end
      for (int i = 0; i < n; i++) begin
         if (perf_clr) begin
            md_pg[k][i] = 0;
            md_pw[k][i] = 0;
         end else begin
            if (w == i) md_pg[k][i]++;
            if (stall[i]) md_pw[k][i]++;
         end
      end
      md_done[k] = nd;
   endtask

   task automatic check_model(input int k);
      cmp("done", k, o_done[k], md_done[k]);
      cmp("stall", k, o_stall[k], req & ~md_done[k] & msk(k));
      cmp("bus_req", k, o_breq[k], md_busy[k] && !md_acc[k]);
      cmp("rdata", k, o_rdata[k], md_rdata[k]);
      cmp("bus_fields", k, o_fields[k], md_fields[k]);
`ifdef ARB_PERF_CNT_EN
      for (int i = 0; i < ((k == 0) ? 2 : 4); i++) begin
         cmp("perf_grant", k*10 + i, (k == 0) ? fp_pg[i*32 +: 32] : rr_pg[i*32 +: 32], md_pg[k][i]);
         cmp("perf_wait", k*10 + i, (k == 0) ? fp_pw[i*32 +: 32] : rr_pw[i*32 +: 32], md_pw[k][i]);
      end
`endif
   endtask

   task automatic cycle_begin();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic cycle_end();
      @(negedge clk);
      check_model(0);
      check_model(1);
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic        a_ok;
      logic        d_ok;
      logic [31:0] rd;
      logic        e_breq;
      logic [1:0]  e_done;
      logic [1:0]  e_stall;
      logic [31:0] e_rdata;
      logic [31:0] e_addr;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] rq, input logic ao, input logic dd,
                      input logic [31:0] rd, input logic eb, input logic [1:0] ed,
                      input logic [1:0] es, input logic [31:0] er, input logic [31:0] ea);
      vec_t v;
      v = '{r, rq, ao, dd, rd, eb, ed, es, er, ea};
      tbl.push_back(v);
   endtask

   int rr_seen[$];
   int fp_seen[$];
   int exp_rr[5] = '{0, 1, 2, 3, 0};
   int exp_fp[4] = '{0, 1, 0, 1};

   initial begin
      // Table phase: m0 writes 0xDEADBEEF/0011 to 0x80000010, m1 reads 0xBFC00000.
      wr = 4'b0001;
      wstrb = {4'hF, 4'hF, 4'hF, 4'b0011};
      addr[31:0] = 32'h8000_0010;  addr[63:32] = 32'hBFC0_0000;
      wdata[31:0] = 32'hDEAD_BEEF; wdata[63:32] = 32'h0;
      add(1, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h0,        32'h0);
      add(0, 2'b10, 0, 0, 0,            0, 2'b00, 2'b10, 32'h0,        32'h0);
      add(0, 2'b10, 1, 0, 0,            1, 2'b00, 2'b10, 32'h0,        32'hBFC0_0000);
      add(0, 2'b10, 0, 0, 0,            0, 2'b00, 2'b10, 32'h0,        32'h0);
      add(0, 2'b10, 0, 1, 32'h2408_0001, 0, 2'b00, 2'b10, 32'h0,        32'h0);
      add(0, 2'b10, 0, 0, 0,            0, 2'b10, 2'b00, 32'h2408_0001, 32'h0);
      add(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h2408_0001, 32'h0);
      add(0, 2'b01, 0, 0, 0,            0, 2'b00, 2'b01, 32'h2408_0001, 32'h0);
      add(0, 2'b01, 1, 1, 32'h1111_1111, 1, 2'b00, 2'b01, 32'h2408_0001, 32'h8000_0010);
      add(0, 2'b01, 0, 0, 0,            0, 2'b01, 2'b00, 32'h2408_0001, 32'h0);
      add(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h2408_0001, 32'h0);
      add(0, 2'b11, 0, 0, 0,            0, 2'b00, 2'b11, 32'h2408_0001, 32'h0);
      add(0, 2'b11, 1, 1, 0,            1, 2'b00, 2'b11, 32'h2408_0001, 32'h8000_0010);
      add(0, 2'b11, 0, 0, 0,            0, 2'b01, 2'b10, 32'h2408_0001, 32'h0);
      add(0, 2'b11, 1, 1, 32'hCAFE_F00D, 1, 2'b00, 2'b11, 32'h2408_0001, 32'hBFC0_0000);
      add(0, 2'b11, 0, 0, 0,            0, 2'b10, 2'b01, 32'hCAFE_F00D, 32'h0);
      add(0, 2'b01, 1, 1, 0,            1, 2'b00, 2'b01, 32'hCAFE_F00D, 32'h8000_0010);
      add(0, 2'b00, 0, 0, 0,            0, 2'b01, 2'b00, 32'hCAFE_F00D, 32'h0);
      add(0, 2'b10, 0, 0, 0,            0, 2'b00, 2'b10, 32'hCAFE_F00D, 32'h0);
      add(0, 2'b10, 1, 0, 0,            1, 2'b00, 2'b10, 32'hCAFE_F00D, 32'hBFC0_0000);
      add(1, 2'b10, 0, 0, 0,            0, 2'b00, 2'b10, 32'hCAFE_F00D, 32'h0);
      add(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h0,        32'h0);
      add(0, 2'b00, 0, 1, 32'hBAD0_BAD0, 0, 2'b00, 2'b00, 32'h0,        32'h0);
      add(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h0,        32'h0);
      add(0, 2'b10, 0, 0, 0,            0, 2'b00, 2'b10, 32'h0,        32'h0);
      add(0, 2'b10, 1, 1, 32'h1234_5678, 1, 2'b00, 2'b10, 32'h0,        32'hBFC0_0000);
      add(0, 2'b10, 0, 0, 0,            0, 2'b10, 2'b00, 32'h1234_5678, 32'h0);
      add(0, 2'b00, 0, 0, 0,            0, 2'b00, 2'b00, 32'h1234_5678, 32'h0);

      cycle_begin();
      for (int r = 0; r < tbl.size(); r++) begin
         rst = tbl[r].rst;
         req = {2'b00, tbl[r].req};
         addr_ok = tbl[r].a_ok;
         data_ok = tbl[r].d_ok;
         rdata_in = tbl[r].rd;
         cycle_end();
         cmp("tbl_bus_req", r, fp_bus_req, tbl[r].e_breq);
         cmp("tbl_done", r, fp_done, tbl[r].e_done);
         cmp("tbl_stall", r, fp_stall, tbl[r].e_stall);
         cmp("tbl_rdata", r, fp_rdata, tbl[r].e_rdata);
         if (tbl[r].e_breq) cmp("tbl_addr", r, fp_bus_addr, tbl[r].e_addr);
         cycle_begin();
      end

      // All masters requesting with immediate bus responses: check grant order.
      rst = 1; req = '0; addr_ok = 0; data_ok = 0;
      cycle_end();
      cycle_begin();
      rst = 0;
      for (int i = 0; i < 4; i++) addr[i*32 +: 32] = 32'h1000_0000 + 32'(i * 256);
      req = 4'hF; addr_ok = 1; data_ok = 1;
      cycle_end();
      for (int c = 0; c < 40 && (rr_seen.size() < 5 || fp_seen.size() < 4); c++) begin
         cycle_begin();
         cycle_end();
         if (rr_bus_req) rr_seen.push_back(int'((rr_bus_addr - 32'h1000_0000) >> 8));
         if (fp_bus_req) fp_seen.push_back(int'((fp_bus_addr - 32'h1000_0000) >> 8));
      end
      for (int i = 0; i < 5; i++) cmp("rr_order", i, (i < rr_seen.size()) ? rr_seen[i] : 99, exp_rr[i]);
      for (int i = 0; i < 4; i++) cmp("fp_order", i, (i < fp_seen.size()) ? fp_seen[i] : 99, exp_fp[i]);

`ifdef ARB_PERF_CNT_EN
      // Three grants to master 1, two stall cycles each, then clear.
      cycle_begin(); rst = 1; req = '0; addr_ok = 0; data_ok = 0; cycle_end();
      cycle_begin(); rst = 0; cycle_end();
      repeat (3) begin
         cycle_begin(); req = 4'b0010; cycle_end();
         cycle_begin(); addr_ok = 1; data_ok = 1; cycle_end();
         cycle_begin(); addr_ok = 0; data_ok = 0; req = '0; cycle_end();
      end
      cycle_begin(); cycle_end();
      cmp("perf_grant_m1", 1, fp_pg[63:32], 32'd3);
      cmp("perf_wait_m1", 1, fp_pw[63:32], 32'd6);
      cycle_begin(); perf_clr = 1; cycle_end();
      cycle_begin(); perf_clr = 0; cycle_end();
      cmp("perf_grant_clr", 1, fp_pg[63:32], 32'd0);
      cmp("perf_wait_clr", 1, fp_pw[63:32], 32'd0);
`endif

      // Randomised traffic, random bus responses, occasional reset and counter clear.
      cycle_begin();
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         perf_clr = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               wr[i] = 1'($urandom_range(0, 1));
               wstrb[i*4 +: 4] = 4'($urandom_range(0, 15));
               addr[i*32 +: 32] = $urandom;
               wdata[i*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 15) == 0) addr[i*32 +: 32] = $urandom;
         end
         addr_ok = 1'($urandom_range(0, 1));
         data_ok = ($urandom_range(0, 2) != 0);
         rdata_in = $urandom;
         cycle_end();
         cycle_begin();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
